// File: rtl/sj_method_call_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : sj_method_call_arbiter
// Purpose  : Round-robin sharing of one Synthesijer method call port
//            (req/busy/return) among N_REQ requesters, with start-wait and
//            busy-timeout supervision. Optional call/timeout statistics are
//            enabled by defining SJ_ARB_STATS_EN.
// Revision : 1.0 - initial release
// =============================================================================
module sj_method_call_arbiter #(
  parameter int N_REQ      = 4,
  parameter int RET_W      = 32,
  parameter int START_WAIT = 4,
  parameter int TIMEOUT    = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] call_req,
  output logic [N_REQ-1:0] call_grant,
  output logic [N_REQ-1:0] call_done,
  output logic [N_REQ-1:0] call_timeout,
  output logic [RET_W-1:0] call_ret,
  output logic             m_req,
  input  logic             m_busy,
  input  logic [RET_W-1:0] m_return,
  output logic             arb_idle,
  output logic [15:0]      stat_calls,
  output logic [15:0]      stat_timeouts
);

  localparam int c_IDX_W   = $clog2(N_REQ);
  localparam int c_CNT_MAX = (TIMEOUT > START_WAIT) ? TIMEOUT : START_WAIT;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_IDX_W:0]   c_N          = (c_IDX_W+1)'(N_REQ);
  localparam logic [c_IDX_W-1:0] c_LAST       = c_IDX_W'(N_REQ-1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE    = c_IDX_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_WAIT-1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST    = c_CNT_W'(TIMEOUT-1);

  localparam logic [2:0] c_ST_IDLE       = 3'd0;
  localparam logic [2:0] c_ST_ISSUE      = 3'd1;
  localparam logic [2:0] c_ST_WAIT_START = 3'd2;
  localparam logic [2:0] c_ST_WAIT_DONE  = 3'd3;
  localparam logic [2:0] c_ST_COMPLETE   = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [c_IDX_W-1:0] r_ptr;
  logic [c_IDX_W-1:0] r_win;
  logic [c_IDX_W-1:0] w_sel;
  logic [c_IDX_W:0]   w_k;
  logic               w_any;
  logic [c_CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0]   r_grant;
  logic [RET_W-1:0]   r_ret;
  logic               w_start_last;
  logic               w_timeout_hit;

  // First requester at or after the pointer, scanning with wrap-around.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    w_k   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_k = {1'b0, r_ptr} + (c_IDX_W+1)'(i);
      if (w_k >= c_N) w_k = w_k - c_N;
      if (!w_any && call_req[w_k[c_IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_k[c_IDX_W-1:0];
      end
    end
  end

  assign w_start_last  = (r_cnt == c_START_LAST);
  assign w_timeout_hit = (r_cnt == c_TO_LAST) && m_busy;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:       if (w_any) w_next = c_ST_ISSUE;
      c_ST_ISSUE:      w_next = c_ST_WAIT_START;
      c_ST_WAIT_START: begin
        if (m_busy)            w_next = c_ST_WAIT_DONE;
        else if (w_start_last) w_next = c_ST_COMPLETE;
      end
      c_ST_WAIT_DONE: begin
        if (!m_busy)            w_next = c_ST_COMPLETE;
        else if (w_timeout_hit) w_next = c_ST_IDLE;
      end
      c_ST_COMPLETE:   w_next = c_ST_IDLE;
      default:         w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    m_req        = 1'b0;
    arb_idle     = 1'b0;
    call_done    = '0;
    call_timeout = '0;
    case (r_state)
      c_ST_IDLE:      arb_idle = 1'b1;
      c_ST_ISSUE:     m_req = 1'b1;
      c_ST_WAIT_DONE: if (w_timeout_hit) call_timeout = r_grant;
      c_ST_COMPLETE:  call_done = r_grant;
      default:        ;
    endcase
  end

  // Return value is sampled on the way into COMPLETE so it is valid with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_win   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_ret   <= '0;
    end else begin
      if (w_next != r_state || r_state == c_ST_IDLE) r_cnt <= '0;
      else                                           r_cnt <= r_cnt + c_CNT_ONE;
      if (r_state == c_ST_IDLE && w_any) begin
        r_win   <= w_sel;
        r_grant <= N_REQ'(1) << w_sel;
      end else if (w_next == c_ST_IDLE) begin
        r_grant <= '0;
      end
      if (w_next == c_ST_COMPLETE && r_state != c_ST_COMPLETE) r_ret <= m_return;
      if (w_next == c_ST_IDLE && r_state != c_ST_IDLE)
        r_ptr <= (r_win == c_LAST) ? '0 : r_win + c_IDX_ONE;
    end
  end

  assign call_grant = r_grant;
  assign call_ret   = r_ret;

`ifdef SJ_ARB_STATS_EN
  logic [15:0] r_stat_calls;
  logic [15:0] r_stat_timeouts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_calls    <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (|call_done && r_stat_calls != 16'hFFFF)
        r_stat_calls <= r_stat_calls + 16'd1;
      if (|call_timeout && r_stat_timeouts != 16'hFFFF)
        r_stat_timeouts <= r_stat_timeouts + 16'd1;
    end
  end

  assign stat_calls    = r_stat_calls;
  assign stat_timeouts = r_stat_timeouts;
`else
  assign stat_calls    = '0;
  assign stat_timeouts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sj_method_call_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_sj_method_call_arbiter
// Purpose  : Self-checking bench for sj_method_call_arbiter with a simple
//            method-call model and a pulse scoreboard.
// Revision : 1.0 - initial release
// =============================================================================
module tb_sj_method_call_arbiter;

  localparam int N  = 4;
  localparam int RW = 32;
  localparam int SW = 4;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  call_req = '0;
  logic [N-1:0]  call_grant;
  logic [N-1:0]  call_done;
  logic [N-1:0]  call_timeout;
  logic [RW-1:0] call_ret;
  logic          m_req;
  logic          m_busy = 1'b0;
  logic [RW-1:0] m_return = '0;
  logic          arb_idle;
  logic [15:0]   stat_calls;
  logic [15:0]   stat_timeouts;

  sj_method_call_arbiter #(
    .N_REQ(N), .RET_W(RW), .START_WAIT(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .call_grant(call_grant),
    .call_done(call_done), .call_timeout(call_timeout), .call_ret(call_ret),
    .m_req(m_req), .m_busy(m_busy), .m_return(m_return), .arb_idle(arb_idle),
    .stat_calls(stat_calls), .stat_timeouts(stat_timeouts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  req;
    int            start;    // cycles after m_req until busy rises; <0 never
    int            len;      // busy length; <0 stuck high
    logic [RW-1:0] ret;
    int            exp_idx;
    bit            exp_to;
    int            exp_lat;  // call_req drive to done/timeout, in cycles
  } vec_t;

  typedef struct {
    bit            is_to;
    int            idx;
    logic [RW-1:0] ret;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_mreq = 0;

  int            mdl_start = 1;
  int            mdl_len   = 1;
  logic [RW-1:0] mdl_ret   = '0;
  bit            mdl_by_grant = 1'b0;
  int            mdl_t = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Method model: busy window measured from the m_req cycle (t=0).
  always @(posedge clk) begin
    #2;
    if (reset) mdl_t = -1;
    else if (m_req) begin
      mdl_t = 0;
      if (mdl_by_grant)
        for (int i = 0; i < N; i++) if (call_grant[i]) m_return = RW'(i);
    end else if (mdl_t >= 0) mdl_t++;
    if (!mdl_by_grant) m_return = mdl_ret;
    m_busy = (mdl_start >= 0) && (mdl_t >= mdl_start) &&
             ((mdl_len < 0) || (mdl_t < mdl_start + mdl_len));
  end

  // Scoreboard: every done/timeout pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (m_req) n_mreq++;
    if (|call_done || |call_timeout) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: done=%b timeout=%b required none", call_done, call_timeout);
      end else begin
        e = sb.pop_front();
        check("done_vec", 64'(call_done), e.is_to ? 64'(0) : 64'(N'(1) << e.idx));
        check("timeout_vec", 64'(call_timeout), e.is_to ? 64'(N'(1) << e.idx) : 64'(0));
        check("grant_at_pulse", 64'(call_grant), 64'(N'(1) << e.idx));
        check("call_ret", 64'(call_ret), 64'(e.ret));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    logic [RW-1:0] last_ret;
    exp_t e;
    int lat, mreq0, nd, cyc;
    bit got;

    vecs[0]  = '{4'b0001, 1, 10, 32'h1,    0, 1'b0, 13};
    vecs[1]  = '{4'b0100, 1,  1, 32'h22,   2, 1'b0,  4};
    vecs[2]  = '{4'b0101, 1,  3, 32'h30,   0, 1'b0,  6};
    vecs[3]  = '{4'b0101, 1,  3, 32'h32,   2, 1'b0,  6};
    vecs[4]  = '{4'b1001, 1,  3, 32'h43,   3, 1'b0,  6};
    vecs[5]  = '{4'b0110, 1,  3, 32'h51,   1, 1'b0,  6};
    vecs[6]  = '{4'b0011, 1,  3, 32'h60,   0, 1'b0,  6};
    vecs[7]  = '{4'b1000, -1, 0, 32'hA5,   3, 1'b0,  2 + SW};
    vecs[8]  = '{4'b1111, 1,  3, 32'h5,    0, 1'b0,  6};
    vecs[9]  = '{4'b0010, 1, -1, 32'hDEAD, 1, 1'b1,  2 + TO};
    vecs[10] = '{4'b0010, 1,  2, 32'h77,   1, 1'b0,  5};
    last_ret = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 64'(call_grant), 64'(0));
    check("rst_done", 64'(call_done), 64'(0));
    check("rst_timeout", 64'(call_timeout), 64'(0));
    check("rst_ret", 64'(call_ret), 64'(0));
    check("rst_mreq", 64'(m_req), 64'(0));
    check("rst_idle", 64'(arb_idle), 64'(1));
    check("rst_stats", {32'(stat_calls), 32'(stat_timeouts)}, 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    for (int v = 0; v < 11; v++) begin
      @(posedge clk); #1;
      mdl_start = vecs[v].start;
      mdl_len   = vecs[v].len;
      mdl_ret   = vecs[v].ret;
      e.is_to = vecs[v].exp_to;
      e.idx   = vecs[v].exp_idx;
      e.ret   = vecs[v].exp_to ? last_ret : vecs[v].ret;
      sb.push_back(e);
      if (!vecs[v].exp_to) last_ret = vecs[v].ret;
      mreq0 = n_mreq;
      call_req = vecs[v].req;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 300) begin
        @(negedge clk);
        if (|call_done || |call_timeout) got = 1'b1;
        else lat++;
      end
      check("latency", 64'(lat), 64'(vecs[v].exp_lat));
      check("mreq_pulses", 64'(n_mreq - mreq0), 64'(1));
      @(posedge clk); #1;
      call_req = '0;
      @(negedge clk);
      check("idle_after_call", {63'(call_grant), arb_idle}, 64'(1));
    end
    check("sb_drained", 64'(sb.size()), 64'(0));
`ifdef SJ_ARB_STATS_EN
    check("stat_calls", 64'(stat_calls), 64'(10));
    check("stat_timeouts", 64'(stat_timeouts), 64'(1));
`else
    check("stat_calls", 64'(stat_calls), 64'(0));
    check("stat_timeouts", 64'(stat_timeouts), 64'(0));
`endif

    // Reset while the method is busy: no pulse, everything back to reset state.
    @(posedge clk); #1;
    mdl_start = 1;
    mdl_len   = -1;
    call_req  = 4'b0001;
    repeat (5) @(negedge clk);
    check("midcall_grant", 64'(call_grant), 64'(4'b0001));
    check("midcall_busy", 64'(m_busy), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    call_req = '0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_grant", 64'(call_grant), 64'(0));
    check("midrst_pulses", {32'(call_done), 32'(call_timeout)}, 64'(0));
    check("midrst_mreq", 64'(m_req), 64'(0));
    check("midrst_idle", 64'(arb_idle), 64'(1));
    check("midrst_ret", 64'(call_ret), 64'(0));
    check("midrst_stats", {32'(stat_calls), 32'(stat_timeouts)}, 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Round robin with all four requesters held; pointer restarts at 0.
    #1;
    mdl_start = 1;
    mdl_len   = 2;
    mdl_by_grant = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e.is_to = 1'b0;
      e.idx   = i % N;
      e.ret   = RW'(i % N);
      sb.push_back(e);
    end
    call_req = 4'b1111;
    nd = 0;
    cyc = 0;
    while (nd < 5 && cyc < 500) begin
      @(negedge clk);
      if (|call_done) nd++;
      cyc++;
    end
    @(posedge clk); #1;
    call_req = '0;
    check("rr_done_count", 64'(nd), 64'(5));
    repeat (3) @(negedge clk);
    check("rr_sb_drained", 64'(sb.size()), 64'(0));
    check("rr_idle", 64'(arb_idle), 64'(1));
    check("rr_last_ret", 64'(call_ret), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
